// File: rtl/dynamixel_write_scheduler_pkg.sv
// Shared definitions for the Dynamixel write scheduler: requester count,
// packed field widths, FSM state encoding and grant index helpers.
package dynamixel_write_scheduler_pkg;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 16;
    localparam int LEN_W   = 16;
    localparam int VAL_W   = 32;
    localparam int VALS_W  = 4 * VAL_W;
    localparam int GID_W   = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    // One-hot grant vector to requester index; an empty vector maps to 0.
    function automatic logic [GID_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [GID_W-1:0] idx;
        case (oh)
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Requester index to one-hot vector; index 3 is not a requester.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [GID_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/dynamixel_write_scheduler_if.sv
// Bus between the write scheduler (master) and the sync writer (slave).
interface dynamixel_write_scheduler_if;
    import dynamixel_write_scheduler_pkg::*;

    logic               send;
    logic [ADDR_W-1:0]  address;
    logic [LEN_W-1:0]   data_len;
    logic [VAL_W-1:0]   value1;
    logic [VAL_W-1:0]   value2;
    logic [VAL_W-1:0]   value3;
    logic [VAL_W-1:0]   value4;
    logic               sending;

    modport master (
        output send, address, data_len, value1, value2, value3, value4,
        input  sending
    );

    modport slave (
        input  send, address, data_len, value1, value2, value3, value4,
        output sending
    );

endinterface

// File: rtl/dynamixel_write_scheduler_rr_arbiter3.sv
// Three-way round-robin arbiter: search starts at the requester after the
// last grant. Purely combinational.
module rr_arbiter3
    import dynamixel_write_scheduler_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [GID_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    // Priority rotation selected by the previous grantee.
    always_comb begin
        grant = 3'b000;
        valid = |req;
        case (last_grant)
            2'd0: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else             grant = 3'b000;
            end
            2'd1: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else             grant = 3'b000;
            end
            default: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else             grant = 3'b000;
            end
        endcase
    end

endmodule

// File: rtl/dynamixel_write_scheduler.sv
// Schedules register writes from three requesters onto one sync writer:
// round-robin grant, one-clock send pulse, start timeout, inter-packet gap.
module dynamixel_write_scheduler
    import dynamixel_write_scheduler_pkg::*;
#(
    parameter int gap_clocks    = 100,
    parameter int start_timeout = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ-1:0][LEN_W-1:0]    req_data_len,
    input  logic [NUM_REQ-1:0][VALS_W-1:0]   req_values,
    output logic [NUM_REQ-1:0]               ack,
    output logic                             busy,
    output logic [GID_W-1:0]                 grant_id,
    output logic                             error,
    dynamixel_write_scheduler_if.master      wr
);

    localparam int TW       = (start_timeout > 1) ? $clog2(start_timeout) : 1;
    localparam int GW       = (gap_clocks > 1) ? $clog2(gap_clocks) : 1;
    localparam int TO_LAST  = (start_timeout > 0) ? start_timeout - 1 : 0;
    localparam int GAP_LAST = (gap_clocks > 0) ? gap_clocks - 1 : 0;

    state_t              state_r, state_s;
    logic [TW-1:0]       tcnt_r, tcnt_s;
    logic [GW-1:0]       gcnt_r, gcnt_s;
    logic                send_r, send_s;
    logic [NUM_REQ-1:0]  ack_r, ack_s;
    logic                busy_r, busy_s;
    logic [GID_W-1:0]    grant_id_r, grant_id_s;
    logic                error_r, error_s;
    logic [ADDR_W-1:0]   address_r, address_s;
    logic [LEN_W-1:0]    data_len_r, data_len_s;
    logic [VALS_W-1:0]   values_r, values_s;
    logic [NUM_REQ-1:0]  arb_grant_s;
    logic                arb_valid_s;
    logic [GID_W-1:0]    arb_idx_s;
    logic                take_grant_s;

    rr_arbiter3 u_arb (
        .req        (req),
        .last_grant (grant_id_r),
        .grant      (arb_grant_s),
        .valid      (arb_valid_s)
    );

    assign arb_idx_s   = onehot_to_idx(arb_grant_s);
    assign ack         = ack_r;
    assign busy        = busy_r;
    assign grant_id    = grant_id_r;
    assign error       = error_r;
    assign wr.send     = send_r;
    assign wr.address  = address_r;
    assign wr.data_len = data_len_r;
    assign wr.value1   = values_r[VAL_W-1:0];
    assign wr.value2   = values_r[2*VAL_W-1:VAL_W];
    assign wr.value3   = values_r[3*VAL_W-1:2*VAL_W];
    assign wr.value4   = values_r[4*VAL_W-1:3*VAL_W];

    // Next-state and next-output logic; arbitration happens in IDLE and on
    // the last GAP clock so back-to-back packets lose no cycle.
    always_comb begin
        state_s      = state_r;
        tcnt_s       = tcnt_r;
        gcnt_s       = gcnt_r;
        send_s       = 1'b0;
        ack_s        = 3'b000;
        grant_id_s   = grant_id_r;
        error_s      = error_r;
        address_s    = address_r;
        data_len_s   = data_len_r;
        values_s     = values_r;
        take_grant_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s) take_grant_s = 1'b1;
                else             state_s = ST_IDLE;
            end
            ST_START: begin
                state_s = ST_WAIT_BUSY;
                tcnt_s  = tcnt_r + {{(TW-1){1'b0}}, 1'b1};
            end
            ST_WAIT_BUSY: begin
                if (wr.sending) begin
                    state_s = ST_WAIT_DONE;
                end else if (tcnt_r >= TW'(TO_LAST)) begin
                    error_s = 1'b1;
                    ack_s   = idx_to_onehot(grant_id_r);
                    gcnt_s  = {GW{1'b0}};
                    state_s = ST_GAP;
                end else begin
                    tcnt_s  = tcnt_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            ST_WAIT_DONE: begin
                if (!wr.sending) begin
                    ack_s   = idx_to_onehot(grant_id_r);
                    gcnt_s  = {GW{1'b0}};
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (gcnt_r >= GW'(GAP_LAST)) begin
                    if (arb_valid_s) take_grant_s = 1'b1;
                    else             state_s = ST_IDLE;
                end else begin
                    gcnt_s = gcnt_r + {{(GW-1){1'b0}}, 1'b1};
                end
            end
            default: state_s = ST_IDLE;
        endcase
        if (take_grant_s) begin
            state_s    = ST_START;
            send_s     = 1'b1;
            tcnt_s     = {TW{1'b0}};
            grant_id_s = arb_idx_s;
            address_s  = req_address[arb_idx_s];
            data_len_s = req_data_len[arb_idx_s];
            values_s   = req_values[arb_idx_s];
        end else begin
            send_s     = 1'b0;
        end
        busy_s = (state_s != ST_IDLE);
    end

    // State, counters and all outputs are registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            tcnt_r     <= {TW{1'b0}};
            gcnt_r     <= {GW{1'b0}};
            send_r     <= 1'b0;
            ack_r      <= 3'b000;
            busy_r     <= 1'b0;
            grant_id_r <= 2'd2;
            error_r    <= 1'b0;
            address_r  <= 16'h0000;
            data_len_r <= 16'h0000;
            values_r   <= {VALS_W{1'b0}};
        end else begin
            state_r    <= state_s;
            tcnt_r     <= tcnt_s;
            gcnt_r     <= gcnt_s;
            send_r     <= send_s;
            ack_r      <= ack_s;
            busy_r     <= busy_s;
            grant_id_r <= grant_id_s;
            error_r    <= error_s;
            address_r  <= address_s;
            data_len_r <= data_len_s;
            values_r   <= values_s;
        end
    end

endmodule

// File: doc/dynamixel_write_scheduler.md
DYNAMIXEL_WRITE_SCHEDULER -- requirements
Module: dynamixel_write_scheduler

Interface
REQ-001 SHALL have parameter gap_clocks, default 100: idle clocks enforced between consecutive packets.
REQ-002 SHALL have parameter start_timeout, default 16: max clocks from send pulse to writer sending=1.
REQ-003 SHALL have clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have req  input  3  per-requester write request, level, held until ack.
REQ-006 SHALL have req_address  input  48  three 16-bit register addresses, requester n at [16n+15:16n].
REQ-007 SHALL have req_data_len  input  48  three 16-bit data lengths (1, 2 or 4), same packing.
REQ-008 SHALL have req_values  input  384  three 128-bit groups, requester n at [128n+127:128n], value1 in the low word.
REQ-009 SHALL have ack  output  3  one-clock pulse to the granted requester when its packet completes or aborts.
REQ-010 SHALL have send  output  1  one-clock start pulse to the sync writer.
REQ-011 SHALL have address, data_len  output  16 each  held to the writer.
REQ-012 SHALL have value1..value4  output  32 each  held to the writer.
REQ-013 SHALL have sending  input  1  writer busy flag.
REQ-014 SHALL have busy  output  1  high in any state except IDLE.
REQ-015 SHALL have grant_id  output  2  index of current/last granted requester.
REQ-016 SHALL have error  output  1  sticky start-timeout flag.

Function
REQ-017 SHALL implement states IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
REQ-018 IDLE: if any req bit set, SHALL grant round-robin starting at (last_grant+1) mod 3, latch that requester's address, data_len, values into output registers, set grant_id, go START.
REQ-019 START: SHALL assert send for exactly one clock, go WAIT_BUSY.
REQ-020 WAIT_BUSY: on sending=1 SHALL go WAIT_DONE; if start_timeout clocks elapse first, SHALL set error, pulse ack for the grantee, go GAP.
REQ-021 WAIT_DONE: on sending=0 SHALL pulse ack[grant_id] for one clock and go GAP.
REQ-022 GAP: SHALL count gap_clocks clocks, then go IDLE; gap_clocks=0 SHALL mean direct return to IDLE next clock.
REQ-023 address, data_len, value1..4 SHALL remain constant from grant until GAP exits; requester inputs changing meanwhile SHALL have no effect.
REQ-024 Grant-to-send latency SHALL be one clock; IDLE re-arbitration SHALL occur on the clock GAP ends, no extra dead cycle.
REQ-025 req deasserting after grant SHALL NOT abort the packet; ack still pulses.
REQ-026 A requester re-asserting req the clock after its ack SHALL wait behind other pending requesters (round-robin fairness).
REQ-027 data_len values other than 1, 2, 4 SHALL be passed through unchanged; checking is the requester's responsibility.
REQ-028 Counters SHALL be sized from parameters via clog2, minimum 1 bit; no wrap within one state.

Reset
REQ-029 Reset SHALL force IDLE, send=0, ack=0, busy=0, error=0, grant_id=2 (so requester 0 wins first), address/data_len/values=0, counters=0.
REQ-030 Reset mid-packet SHALL abandon the packet without ack; error only clears on reset.

Structure
REQ-031 State encodings, requester count (3) and packed-field widths SHALL live in a shared dynamixel package.
REQ-032 Round-robin selection SHALL be a sub-module, rr_arbiter3 (req, last grant in; one-hot grant, valid out), purely combinational.
REQ-033 The block SHALL NOT instantiate the writer; integration wires send/sending/address/data_len/values to it.

Verification
REQ-034 req=001, address 116, data_len 4, value1 0x00000800; writer model raises sending 1 clock after send, drops 40 clocks later -> one send pulse, outputs held throughout, ack=001 on drop clock, busy low 100 clocks later.
REQ-035 req=111 from reset -> grants 0,1,2 in order, each separated by >=100 idle clocks, three acks.
REQ-036 Requester 0 re-asserts immediately after ack while 1 pending -> 1 granted before 0.
REQ-037 Writer never raises sending -> error=1 and ack pulse at 16 clocks after send; next request still served.
REQ-038 Reset asserted during WAIT_DONE -> all outputs zero immediately, no ack, grant_id=2.
REQ-039 Change req_values mid-packet -> value1..4 unchanged until GAP exits.
